gpio_bank_ctrl: RTL

//  Direction/data sequencer for a bank of N_GPIO GPIO pad cells (A/Y/PAD/DIR, DIR=1 input, DIR=0 output).

---
 rtl/gpio_bank_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/gpio_bank_ctrl.sv
// gpio_bank_ctrl: direction/data sequencer for a bank of GPIO pad cells.
// A new bank configuration is taken over a valid/ready handshake. When any
// pad changes direction, pads becoming inputs are released first. Pads
// becoming outputs are driven only after a programmable turnaround gap.
// Pad inputs come back through a masked multi-flop synchroniser.
module gpio_bank_ctrl #(
  parameter int N_GPIO      = 8,
  parameter int TURN_CYC    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              pReset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [N_GPIO-1:0] cfg_dir,
  input  logic [N_GPIO-1:0] cfg_dout,
  output logic              cfg_done,
  output logic [N_GPIO-1:0] gpio_dir,
  output logic [N_GPIO-1:0] gpio_a,
  input  logic [N_GPIO-1:0] gpio_y,
  output logic [N_GPIO-1:0] din
);

  // Counter must hold TURN_CYC; keep at least one bit when the gap is zero.
  localparam int CNT_W = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RELEASE = 2'd1,
    S_TURN    = 2'd2,
    S_DRIVE   = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [N_GPIO-1:0]   r_cfg_dir;
  logic [N_GPIO-1:0]   r_cfg_dout;
  logic [N_GPIO-1:0]   r_dir;
  logic [N_GPIO-1:0]   r_a;
  logic                r_done;
  logic [N_GPIO-1:0]   r_sync [SYNC_STAGES];
  logic                w_xfer;

  assign cfg_ready = (r_state == S_IDLE) & ~pReset;
  assign w_xfer    = cfg_valid & cfg_ready;
  assign gpio_dir  = r_dir;
  assign gpio_a    = r_a;
  assign cfg_done  = r_done;
  assign din       = r_sync[SYNC_STAGES-1];

  // Configuration sequencer: accept, release, wait the turnaround, then drive.
  always_ff @(posedge clk) begin
    if (pReset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cfg_dir  <= '0;
      r_cfg_dout <= '0;
      r_dir      <= '1;
      r_a        <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_cfg_dir  <= cfg_dir;
            r_cfg_dout <= cfg_dout;
            // Unchanged direction means a pure data update: skip the gap.
            if (cfg_dir == r_dir) begin
              r_state <= S_DRIVE;
            end else begin
              r_state <= S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          // Pads heading to input let go now; pads heading to output wait.
          r_dir <= r_dir | r_cfg_dir;
          if (TURN_CYC == 0) begin
            r_state <= S_DRIVE;
          end else begin
            r_cnt   <= CNT_W'(TURN_CYC);
            r_state <= S_TURN;
          end
        end
        S_TURN: begin
          // A zero count can only come from corruption; leave rather than stall.
          if (r_cnt <= CNT_W'(1)) begin
            r_state <= S_DRIVE;
          end
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_DRIVE: begin
          // Data and direction land together so a new output never shows stale data.
          r_dir   <= r_cfg_dir;
          r_a     <= r_cfg_dout;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Pad input synchroniser; output pads are masked before the first flop so
  // an undriven Y never reaches the fabric.
  always_ff @(posedge clk) begin
    if (pReset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= gpio_y & r_dir;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

endmodule
